imm_gen_pipe: RTL and testbench

//  Parametrised, registered immediate generator for the decode stage.
//  - Extracts and extends the immediate from instr[31:7] for I/S/B/U/J and CSR-zimm formats.
//  - Carries a sideband tag (normally the PC) alongside each result.
//  - Valid/ready handshakes on both sides, with a 2-entry skid buffer in between.
//  - Sits between fetch/decode and the ID/EX register; keeps a saturating count of illegal selects.

---
 rtl/imm_gen_pipe.sv | 121 ++++++++++++
 tb/tb_imm_gen_pipe.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator with a 2-entry output FIFO.
// Each entry carries the extended immediate, a sideband tag and an illegal-select flag.
module imm_gen_pipe #(
  parameter int XLEN      = 32,
  parameter int TAG_W     = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [24:0]          in_instr,
  input  logic [2:0]           in_sel,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_imm,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [2:0] SEL_I = 3'b000;
  localparam logic [2:0] SEL_S = 3'b001;
  localparam logic [2:0] SEL_B = 3'b010;
  localparam logic [2:0] SEL_U = 3'b011;
  localparam logic [2:0] SEL_J = 3'b100;
  localparam logic [2:0] SEL_Z = 3'b101;

  // ins[k] holds instruction bit k+7; every format is first built as a signed
  // 32-bit value and then sign-extended to XLEN in one place.
  function automatic logic [XLEN-1:0] imm_ext(input logic [24:0] ins, input logic [2:0] sel);
    logic signed [31:0] v;
    case (sel)
      SEL_I:   v = {{20{ins[24]}}, ins[24:13]};
      SEL_S:   v = {{20{ins[24]}}, ins[24:18], ins[4:0]};
      SEL_B:   v = {{19{ins[24]}}, ins[24], ins[0], ins[23:18], ins[4:1], 1'b0};
      SEL_U:   v = {ins[24:5], 12'b0};
      SEL_J:   v = {{11{ins[24]}}, ins[24], ins[12:5], ins[13], ins[23:14], 1'b0};
      SEL_Z:   v = {27'b0, ins[12:8]};
      default: v = '0;
    endcase
    return XLEN'(v);
  endfunction

  function automatic logic is_illegal(input logic [2:0] sel);
    return sel[2] & sel[1];
  endfunction

  logic [XLEN-1:0]      w_imm_p0;
  logic                 w_err_p0;
  logic                 w_push;
  logic                 w_pop;
  logic [1:0]           r_count;
  logic [XLEN-1:0]      r_imm_p1;
  logic [TAG_W-1:0]     r_tag_p1;
  logic                 r_err_p1;
  logic [XLEN-1:0]      r_imm_p2;
  logic [TAG_W-1:0]     r_tag_p2;
  logic                 r_err_p2;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  // Stage p0: combinational extraction from the incoming entry
  assign w_imm_p0 = imm_ext(in_instr, in_sel);
  assign w_err_p0 = is_illegal(in_sel);

  // Ready depends only on stored occupancy, never on out_ready.
  assign in_ready  = rst_n & (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid & in_ready & ~flush;
  assign w_pop     = out_valid & out_ready;

  // Stage p1: head entry (drives the outputs) and occupancy/error state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count   <= 2'd0;
      r_imm_p1  <= '0;
      r_tag_p1  <= '0;
      r_err_p1  <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      if (flush) begin
        r_count <= 2'd0;
      end else begin
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 2'd1;
          2'b01:   r_count <= r_count - 2'd1;
          default: r_count <= r_count;
        endcase
        if (w_push && ((r_count == 2'd0) || ((r_count == 2'd1) && w_pop))) begin
          r_imm_p1 <= w_imm_p0;
          r_tag_p1 <= in_tag;
          r_err_p1 <= w_err_p0;
        end else if (w_pop && (r_count == 2'd2)) begin
          r_imm_p1 <= r_imm_p2;
          r_tag_p1 <= r_tag_p2;
          r_err_p1 <= r_err_p2;
        end
      end
      if (w_push && w_err_p0 && (r_err_cnt != {ERR_CNT_W{1'b1}})) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
    end
  end

  // Stage p2: second slot, only written when the head stays occupied
  always_ff @(posedge clk) begin
    if (w_push && (r_count == 2'd1) && !w_pop) begin
      r_imm_p2 <= w_imm_p0;
      r_tag_p2 <= in_tag;
      r_err_p2 <= w_err_p0;
    end
  end

  assign out_imm = r_imm_p1;
  assign out_tag = r_tag_p1;
  assign out_err = r_err_p1;
  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one
// stimulus stream; a negedge monitor pops expected entries on every DUT pop.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [24:0] in_instr;
  logic [2:0]  in_sel;
  logic [31:0] in_tag;

  logic        in_ready32, out_valid32, out_err32;
  logic [31:0] out_imm32, out_tag32;
  logic [7:0]  err_cnt32;
  logic        in_ready64, out_valid64, out_err64;
  logic [63:0] out_imm64;
  logic [31:0] out_tag64;
  logic [7:0]  err_cnt64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32), .ERR_CNT_W(8)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag), .out_valid(out_valid32),
    .out_ready(out_ready), .out_imm(out_imm32), .out_tag(out_tag32), .out_err(out_err32),
    .err_cnt(err_cnt32));

  imm_gen_pipe #(.XLEN(64), .TAG_W(32), .ERR_CNT_W(8)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_sel(in_sel), .in_tag(in_tag), .out_valid(out_valid64),
    .out_ready(out_ready), .out_imm(out_imm64), .out_tag(out_tag64), .out_err(out_err64),
    .err_cnt(err_cnt64));

  typedef struct {
    logic [63:0] imm;
    logic [31:0] tag;
    logic        err;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          exp_err = 0;
  logic        mon_en = 1'b0;
  logic        last_acc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Reference immediate from the format rules, using whole-word shifts and masks.
  function automatic logic [63:0] ref_imm(input logic [24:0] ins, input logic [2:0] sel);
    logic [31:0] w;
    longint      s;
    longint      u;
    w = {ins, 7'b0};
    s = longint'($signed(w));
    u = longint'({32'b0, w});
    case (sel)
      3'd0:    return s >>> 20;
      3'd1:    return ((s >>> 25) <<< 5) | ((u >> 7) & 31);
      3'd2:    return ((s >>> 31) <<< 12) | (((u >> 7) & 1) << 11) |
                      (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1);
      3'd3:    return s & ~longint'(64'hFFF);
      3'd4:    return ((s >>> 31) <<< 20) | (((u >> 12) & 255) << 12) |
                      (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1);
      3'd5:    return (u >> 15) & 31;
      default: return 64'd0;
    endcase
  endfunction

  // Monitor: occupancy, error count and popped entries against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      if (!rst_n) begin
        chk("in_ready_in_reset", {63'b0, in_ready32}, 64'd0);
      end else begin
        chk("in_ready", {63'b0, in_ready32}, {63'b0, q.size() < 2});
        chk("out_valid", {63'b0, out_valid32}, {63'b0, q.size() != 0});
        chk("out_valid64", {63'b0, out_valid64}, {63'b0, q.size() != 0});
        chk("err_cnt", {56'b0, err_cnt32}, 64'(exp_err));
        if (!flush && out_valid32 && out_ready) begin
          if (q.size() == 0) begin
            chk("pop_with_empty_model", 64'd1, 64'd0);
          end else begin
            exp_t e;
            e = q.pop_front();
            chk("imm32", {32'b0, out_imm32}, {32'b0, e.imm[31:0]});
            chk("imm64", out_imm64, e.imm);
            chk("tag", {32'b0, out_tag32}, {32'b0, e.tag});
            chk("tag64", {32'b0, out_tag64}, {32'b0, e.tag});
            chk("err", {63'b0, out_err32}, {63'b0, e.err});
          end
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [24:0] ins, input logic [2:0] s,
                       input logic [31:0] t, input logic ordy, input logic fl, input logic rn);
    @(posedge clk);
    #1;
    in_valid = v; in_instr = ins; in_sel = s; in_tag = t;
    out_ready = ordy; flush = fl; rst_n = rn;
    @(negedge clk);
    #1;
    last_acc = 1'b0;
    if (!rst_n) begin
      q.delete();
      exp_err = 0;
    end else if (flush) begin
      q.delete();
    end else if (in_valid && in_ready32) begin
      exp_t e;
      e.imm = ref_imm(in_instr, in_sel);
      e.tag = in_tag;
      e.err = (in_sel >= 3'd6);
      q.push_back(e);
      if (e.err && exp_err < 255) exp_err++;
      last_acc = 1'b1;
    end
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 25'd0, 3'd0, 32'd0, ordy, 1'b0, 1'b1);
  endtask

  task automatic push_until(input logic [31:0] instr, input logic [2:0] s,
                            input logic [31:0] t, input logic ordy);
    int n = 0;
    do begin
      drive(1'b1, instr[31:7], s, t, ordy, 1'b0, 1'b1);
      n++;
    end while (!last_acc && n < 20);
    if (!last_acc) chk("push_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    logic [31:0] ri;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_sel = '0; in_tag = '0; last_acc = 1'b0;
    drive(1'b1, 25'h1FFFFFF, 3'd7, 32'hDEAD, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    drive(1'b0, 25'd0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("rst_out_valid", {63'b0, out_valid32}, 64'd0);
    chk("rst_out_imm", {32'b0, out_imm32}, 64'd0);
    chk("rst_out_tag", {32'b0, out_tag32}, 64'd0);
    chk("rst_out_err", {63'b0, out_err32}, 64'd0);
    chk("rst_err_cnt", {56'b0, err_cnt32}, 64'd0);
    idle(1'b1);
    chk("in_ready_after_release", {63'b0, in_ready32}, 64'd1);

    // Known-answer vectors, one cycle after each push
    push_until(32'hFFF00093, 3'd0, 32'h10, 1'b1); idle(1'b1);
    chk("I_valid", {63'b0, out_valid32}, 64'd1);
    chk("I_imm", {32'b0, out_imm32}, 64'hFFFFFFFF);
    push_until(32'hFE000EE3, 3'd2, 32'h14, 1'b1); idle(1'b1);
    chk("B_imm", {32'b0, out_imm32}, 64'hFFFFFFFC);
    push_until(32'hFE112E23, 3'd1, 32'h18, 1'b1); idle(1'b1);
    chk("S_imm", {32'b0, out_imm32}, 64'hFFFFFFFC);
    push_until(32'h800000B7, 3'd3, 32'h1C, 1'b1); idle(1'b1);
    chk("U_imm64", out_imm64, 64'hFFFFFFFF80000000);
    chk("U_imm32", {32'b0, out_imm32}, 64'h80000000);
    push_until(32'h000F8073, 3'd5, 32'h20, 1'b1); idle(1'b1);
    chk("Z_imm64", out_imm64, 64'h1F);
    push_until(32'h12345678, 3'd7, 32'h24, 1'b1); idle(1'b1);
    chk("ILL_imm", out_imm64, 64'd0);
    chk("ILL_err", {63'b0, out_err32}, 64'd1);
    chk("ILL_cnt", {56'b0, err_cnt32}, 64'd1);

    // Backpressure: third push must wait until a slot frees up
    push_until(32'h00100093, 3'd0, 32'd1, 1'b0);
    push_until(32'h00200093, 3'd0, 32'd2, 1'b0);
    drive(1'b1, 25'h00300093 >> 7, 3'd0, 32'd3, 1'b0, 1'b0, 1'b1);
    chk("full_not_accepted", {63'b0, last_acc}, 64'd0);
    chk("full_in_ready", {63'b0, in_ready32}, 64'd0);
    chk("full_head_tag", {32'b0, out_tag32}, 64'd1);
    push_until(32'h00300093, 3'd0, 32'd3, 1'b1);
    repeat (4) idle(1'b1);

    // Flush a full buffer; the push presented with flush is dropped
    push_until(32'hFFF00093, 3'd6, 32'd40, 1'b0);
    push_until(32'hFFF00093, 3'd0, 32'd41, 1'b0);
    drive(1'b1, 25'h1ABCDEF, 3'd7, 32'd42, 1'b1, 1'b1, 1'b1);
    idle(1'b1);
    chk("flush_out_valid", {63'b0, out_valid32}, 64'd0);
    chk("flush_err_cnt", {56'b0, err_cnt32}, 64'd2);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      ri = $urandom;
      drive(($urandom_range(0, 3) != 0), ri[31:7], 3'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0), 1'b1);
    end
    repeat (4) idle(1'b1);

    // Saturation of the illegal-select counter
    for (int i = 0; i < 300; i++) begin
      ri = $urandom;
      drive(1'b1, ri[31:7], 3'd6 + 3'(i & 1), 32'(i), 1'b1, 1'b0, 1'b1);
    end
    idle(1'b1);
    chk("err_cnt_saturated", {56'b0, err_cnt32}, 64'd255);
    chk("err_cnt_saturated64", {56'b0, err_cnt64}, 64'd255);

    // Reset with a full buffer discards everything and clears the counter
    push_until(32'hFFF00093, 3'd0, 32'd50, 1'b0);
    push_until(32'hFFF00093, 3'd4, 32'd51, 1'b0);
    drive(1'b0, 25'd0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    chk("reset_out_valid", {63'b0, out_valid32}, 64'd0);
    chk("reset_err_cnt", {56'b0, err_cnt32}, 64'd0);
    chk("reset_out_imm", out_imm64, 64'd0);
    chk("reset_out_tag", {32'b0, out_tag64}, 64'd0);
    repeat (3) idle(1'b1);
    chk("model_drained", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
